ysyx_25050147_mem_arbiter: RTL
==============================

Name: ysyx_25050147_mem_arbiter

Overview:
- Two-master, single-slave memory arbiter with a sequencing FSM.
- Shares one memory port between the instruction-fetch unit (master 0, IFU) and the load/store unit (master 1, LSU) of the ysyx_25050147 core.
- Grants use round-robin on ties. One transaction is outstanding at a time. Payload is latched at acceptance, and the response is routed back to the granted master.
- A watchdog terminates hung transactions with an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. The write mask is DATA_W/8 bits.
- TIMEOUT_CYC, 255, maximum cycles spent in REQ+WAIT before forced error termination. Must be at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_addr  in  ADDR_W  IFU fetch address.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_rsp_valid  out  1  one-cycle IFU response pulse.
- ifu_rsp_rdata  out  DATA_W  IFU read data.
- ifu_rsp_err  out  1  IFU response is a timeout error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_addr  in  ADDR_W  LSU address.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_wdata  in  DATA_W  LSU write data.
- lsu_req_wmask  in  DATA_W/8  LSU byte enables.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_rsp_valid  out  1  one-cycle LSU response pulse.
- lsu_rsp_rdata  out  DATA_W  LSU read data.
- lsu_rsp_err  out  1  LSU timeout error.
- mem_req_valid  out  1  request to memory.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_wen  out  1  latched write enable.
- mem_req_wdata  out  DATA_W  latched write data.
- mem_req_wmask  out  DATA_W/8  latched mask.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high on rst):
  - state = IDLE, grant = none, last_grant = LSU, so IFU wins the first tie.
  - Watchdog counter = 0; latched payload = 0.
  - All outputs are 0 while rst is high and on its release.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If exactly one master has valid, grant it.
  - If both have valid, grant the master not equal to last_grant.
  - The granted master's req_ready is 1 combinationally in this cycle; the other master's ready is 0.
  - At posedge: latch the payload (IFU: wen=0, wdata=0, wmask=0), record grant, set last_grant = grant, go to REQ.
  - With no valid, stay in IDLE.
- REQ:
  - mem_req_valid=1, driving the latched payload.
  - When mem_req_ready=1, go to WAIT at posedge.
  - Payload must not change while in REQ.
- WAIT:
  - mem_req_valid=0.
  - When mem_rsp_valid=1, in the same cycle the granted master gets rsp_valid=1 and rsp_rdata=mem_rsp_rdata (combinational pass-through), rsp_err=0. Go to IDLE.
  - Writes also receive a response pulse; rdata is don't-care.
- Throughput: earliest next acceptance is the cycle after the response. Minimum transaction is 3 cycles: accept, REQ with ready, WAIT with rsp.
- Watchdog:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter equals TIMEOUT_CYC-1 and the transaction is not completing that cycle:
    - Pulse the granted master's rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
    - Deassert mem_req_valid and go to IDLE.
  - A real response in the same cycle wins, with err=0.
- mem_rsp_valid in IDLE or REQ is ignored: no response pulse, no state change.
- Non-granted master: req_ready=0, rsp_valid=0, rdata=0, err=0.
- Requesters hold valid and payload until ready. Dropping valid before ready is legal and is simply not accepted.
- Reset asserted mid-transaction aborts immediately: no response is generated, and the memory side must tolerate the abort.
- busy=1 in REQ and WAIT.

Test Plan:
- **Single IFU read:** ifu_req_valid=1, addr=0x80000000; mem ready in REQ; rsp after 2 WAIT cycles with rdata=0x00100073. Expect:
  - ifu_req_ready for 1 cycle, then mem_req_addr=0x80000000 with wen=0.
  - ifu_rsp_valid pulse with rdata=0x00100073, err=0.
  - lsu outputs stay 0.
- **Tie round-robin:** both valid continuously from reset release, IFU addr 0x80000004, LSU write addr 0x80001000, wdata 0xDEADBEEF, mask 0xF; memory responds in 1 cycle. Expect:
  - Grant order IFU, LSU, IFU, LSU.
  - The LSU mem request carries wen=1 and wdata 0xDEADBEEF.
  - Each transaction takes 3 cycles.
- **Backpressure:** LSU read with mem_req_ready held 0 for 5 cycles. Expect mem_req_valid=1 and a stable payload for all 6 REQ cycles, then a normal response.
- **Timeout:** TIMEOUT_CYC=8, IFU request, memory never responds. Expect:
  - ifu_rsp_valid=1 with err=1 and rdata=0 exactly 8 cycles after entering REQ.
  - FSM back in IDLE; a subsequent request is served normally.
- **Spurious and reset:** mem_rsp_valid pulsed in IDLE, which must produce no rsp. Then rst asserted while in WAIT. Expect:
  - All outputs 0 asynchronously.
  - After release, the first tie goes to IFU.

Source files
------------

// File: rtl/ysyx_25050147_mem_arbiter_if.sv
// ysyx_25050147 memory arbiter bus bundle.
// IFU and LSU request/response channels plus the shared memory port.
interface ysyx_25050147_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                ifu_req_valid;
  logic [ADDR_W-1:0]   ifu_req_addr;
  logic                ifu_req_ready;
  logic                ifu_rsp_valid;
  logic [DATA_W-1:0]   ifu_rsp_rdata;
  logic                ifu_rsp_err;

  logic                lsu_req_valid;
  logic [ADDR_W-1:0]   lsu_req_addr;
  logic                lsu_req_wen;
  logic [DATA_W-1:0]   lsu_req_wdata;
  logic [DATA_W/8-1:0] lsu_req_wmask;
  logic                lsu_req_ready;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rsp_rdata;
  logic                lsu_rsp_err;

  logic                mem_req_valid;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_wen;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wmask;
  logic                mem_req_ready;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_rdata;

  // arbiter side
  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid,
    output ifu_rsp_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_req_addr,
    input  lsu_req_wen, lsu_req_wdata,
    input  lsu_req_wmask,
    output lsu_req_ready, lsu_rsp_valid,
    output lsu_rsp_rdata, lsu_rsp_err,
    output mem_req_valid, mem_req_addr,
    output mem_req_wen, mem_req_wdata,
    output mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rsp_rdata
  );

  // requesters and memory side
  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid,
    input  ifu_rsp_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_req_addr,
    output lsu_req_wen, lsu_req_wdata,
    output lsu_req_wmask,
    input  lsu_req_ready, lsu_rsp_valid,
    input  lsu_rsp_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_req_addr,
    input  mem_req_wen, mem_req_wdata,
    input  mem_req_wmask,
    output mem_req_ready, mem_rsp_valid,
    output mem_rsp_rdata
  );
endinterface

// File: rtl/ysyx_25050147_mem_arbiter.sv
// ysyx_25050147 IFU/LSU memory arbiter.
// Round-robin grant, one outstanding transaction, watchdog timeout.
module ysyx_25050147_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_25050147_mem_arbiter_if.slave bus,
  output logic busy
);
  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] p_addr;
  logic              p_wen;
  logic [DATA_W-1:0] p_wdata;
  logic [MW-1:0]     p_wmask;

  logic in_idle;
  logic in_req;
  logic in_wait;
  logic pick_lsu;
  logic accept;
  logic done;
  logic tmo;
  logic fire;

  assign in_idle = (state == S_IDLE);
  assign in_req  = (state == S_REQ);
  assign in_wait = (state == S_WAIT);

  // grant bit 1 means LSU; on a tie the loser of last time wins
  assign pick_lsu = bus.lsu_req_valid &
                    (~bus.ifu_req_valid | ~last_grant);
  assign accept   = in_idle & ~rst &
                    (bus.ifu_req_valid | bus.lsu_req_valid);

  assign done = in_wait & bus.mem_rsp_valid;
  assign tmo  = ~in_idle & (cnt == CNT_LAST) & ~done;
  assign fire = done | tmo;

  assign bus.ifu_req_ready = accept & ~pick_lsu;
  assign bus.lsu_req_ready = accept & pick_lsu;

  assign bus.ifu_rsp_valid = fire & ~grant;
  assign bus.ifu_rsp_err   = tmo & ~grant;
  assign bus.ifu_rsp_rdata = (done & ~grant) ?
                             bus.mem_rsp_rdata : '0;

  assign bus.lsu_rsp_valid = fire & grant;
  assign bus.lsu_rsp_err   = tmo & grant;
  assign bus.lsu_rsp_rdata = (done & grant) ?
                             bus.mem_rsp_rdata : '0;

  assign bus.mem_req_valid = in_req & ~tmo;
  assign bus.mem_req_addr  = p_addr;
  assign bus.mem_req_wen   = p_wen;
  assign bus.mem_req_wdata = p_wdata;
  assign bus.mem_req_wmask = p_wmask;

  assign busy = ~in_idle;

  // sequencing: accept -> REQ -> WAIT -> IDLE, watchdog exits early
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (1'b1)
        in_req: begin
          if (tmo)
            state <= S_IDLE;
          else if (bus.mem_req_ready)
            state <= S_WAIT;
        end
        in_wait: begin
          if (fire)
            state <= S_IDLE;
        end
        default: begin
          if (accept) begin
            state      <= S_REQ;
            grant      <= pick_lsu;
            last_grant <= pick_lsu;
          end
        end
      endcase
    end
  end

  // payload latch at acceptance and watchdog cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      p_addr  <= '0;
      p_wen   <= 1'b0;
      p_wdata <= '0;
      p_wmask <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (pick_lsu) begin
        p_addr  <= bus.lsu_req_addr;
        p_wen   <= bus.lsu_req_wen;
        p_wdata <= bus.lsu_req_wdata;
        p_wmask <= bus.lsu_req_wmask;
      end else begin
        p_addr  <= bus.ifu_req_addr;
        p_wen   <= 1'b0;
        p_wdata <= '0;
        p_wmask <= '0;
      end
    end else if (~in_idle & ~fire) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule
